// File: rtl/uart_tx_dev.sv
// uart_tx_dev: bus-slave 8N1 UART transmitter with TX FIFO, baud divider and drain interrupt
module uart_tx_dev #(
    parameter int          FifoDepth    = 16,
    parameter logic [15:0] DefaultDiv   = 16'd433,
    parameter int          AddressWidth = 32,
    parameter int          DataWidth    = 32
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    req_i,
    input  logic                    we_i,
    input  logic [3:0]              be_i,
    input  logic [AddressWidth-1:0] addr_i,
    input  logic [DataWidth-1:0]    wdata_i,
    output logic                    rvalid_o,
    output logic [DataWidth-1:0]    rdata_o,
    output logic                    err_o,
    output logic                    tx_o,
    output logic                    irq_o
);
    localparam int PW = $clog2(FifoDepth);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] START = 2'd1;
    localparam logic [1:0] DATA  = 2'd2;
    localparam logic [1:0] STOP  = 2'd3;

    logic [7:0]           mem [FifoDepth];
    logic [PW:0]          wptr, rptr;
    logic [15:0]          div, cnt, cnt_n;
    logic [1:0]           ctrl, state, state_n, sel;
    logic [2:0]           idx, idx_n;
    logic [7:0]           shift, shift_n;
    logic                 ovf, empty, full, busy, pop, push_req, push, sts_rd;
    logic [DataWidth-1:0] rd_mux;
    logic                 unused;

    assign sel      = addr_i[3:2];
    assign empty    = wptr == rptr;
    assign full     = (wptr[PW] != rptr[PW]) && (wptr[PW-1:0] == rptr[PW-1:0]);
    assign busy     = state != IDLE;
    assign push_req = req_i & we_i & (sel == 2'd0) & be_i[0];
    assign push     = push_req & ~full;
    assign sts_rd   = req_i & ~we_i & (sel == 2'd1);
    assign rd_mux   = sel == 2'd1 ? DataWidth'({busy, ovf, empty, full}) :
                      sel == 2'd2 ? DataWidth'(div) :
                      sel == 2'd3 ? DataWidth'(ctrl) : '0;
    assign unused   = ^{addr_i[AddressWidth-1:4], addr_i[1:0], be_i[3:2], wdata_i[DataWidth-1:16]};

    // Serializer next state: each bit lasts DIV+1 cycles; pops happen in IDLE or at the end of STOP
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        idx_n   = idx;
        shift_n = shift;
        pop     = 1'b0;
        if (state != IDLE && cnt != '0) begin
            cnt_n = cnt - 16'd1;
        end else begin
            cnt_n = div;
            case (state)
                START: begin
                    state_n = DATA;
                    idx_n   = 3'd0;
                end
                DATA: begin
                    shift_n = shift >> 1;
                    idx_n   = idx + 3'd1;
                    state_n = idx == 3'd7 ? STOP : DATA;
                end
                default: begin
                    pop     = ctrl[0] & ~empty;
                    state_n = pop ? START : IDLE;
                    shift_n = pop ? mem[rptr[PW-1:0]] : shift;
                end
            endcase
        end
    end

    // Serializer registers; tx_o is registered from the next state so it is glitch-free
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state <= IDLE;
            cnt   <= '0;
            idx   <= '0;
            shift <= '0;
            tx_o  <= 1'b1;
            irq_o <= 1'b0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            idx   <= idx_n;
            shift <= shift_n;
            tx_o  <= state_n == START ? 1'b0 : state_n == DATA ? shift_n[0] : 1'b1;
            irq_o <= ctrl[1] & empty & ~busy;
        end
    end

    // FIFO pointers and sticky overflow flag, cleared by a STATUS read
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wptr <= '0;
            rptr <= '0;
            ovf  <= 1'b0;
        end else begin
            wptr <= wptr + (PW+1)'(push);
            rptr <= rptr + (PW+1)'(pop);
            ovf  <= (push_req & full) ? 1'b1 : sts_rd ? 1'b0 : ovf;
        end
    end

    // FIFO storage; contents are meaningless once the pointers reset
    always_ff @(posedge clk_i) begin
        if (push) mem[wptr[PW-1:0]] <= wdata_i[7:0];
    end

    // DIV and CTRL registers with byte-enable gated writes
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            div  <= DefaultDiv;
            ctrl <= '0;
        end else if (req_i && we_i) begin
            if (sel == 2'd2 && be_i[0]) div[7:0]  <= wdata_i[7:0];
            if (sel == 2'd2 && be_i[1]) div[15:8] <= wdata_i[15:8];
            if (sel == 2'd3 && be_i[0]) ctrl      <= wdata_i[1:0];
        end
    end

    // Bus response, one cycle after each request
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rvalid_o <= 1'b0;
            rdata_o  <= '0;
            err_o    <= 1'b0;
        end else begin
            rvalid_o <= req_i;
            rdata_o  <= (req_i & ~we_i) ? rd_mux : '0;
            err_o    <= (req_i & we_i & (sel == 2'd1)) | (push_req & full);
        end
    end
endmodule

// File: tb/tb_uart_tx_dev.sv
// tb_uart_tx_dev: scoreboard bench for the UART transmitter bus slave
module tb_uart_tx_dev;
    logic        clk = 0, rst_n = 0, req = 0, we = 0;
    logic [3:0]  be = 0;
    logic [31:0] addr = 0, wdata = 0;
    logic        rvalid, err, tx, irq;
    logic [31:0] rdata;

    uart_tx_dev dut (
        .clk_i(clk), .rst_ni(rst_n), .req_i(req), .we_i(we), .be_i(be), .addr_i(addr),
        .wdata_i(wdata), .rvalid_o(rvalid), .rdata_o(rdata), .err_o(err), .tx_o(tx), .irq_o(irq)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        string       nm;
    } resp_t;

    resp_t      exp_q[$];
    logic [7:0] tx_exp_q[$];
    int         starts[$];
    int         cyc = 0, pass = 0, total = 0, bit_len = 4;
    bit         tx_on = 0, mon_busy = 0;
    logic       req_seen = 0;

    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) req_seen <= req;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    endtask

    task automatic issue(input logic w, input logic [1:0] off, input logic [3:0] b, input logic [31:0] d,
                         input logic [31:0] er, input logic ee, input string nm, output int t);
        resp_t e;
        req = 1; we = w; addr = {28'h0, off, 2'b00}; be = b; wdata = d;
        e.rdata = er; e.err = ee; e.nm = nm;
        exp_q.push_back(e);
        @(negedge clk);
        t = cyc;
        req = 0; we = 0; be = 0;
    endtask

    task automatic wait_drain(input int maxc, input string nm);
        int n = 0;
        while ((tx_exp_q.size() != 0 || mon_busy) && n < maxc) begin
            @(negedge clk);
            n++;
        end
        chk(nm, n < maxc, 1);
    endtask

    // bus response monitor: rvalid must follow each request by one cycle, data comes from the queue
    always @(negedge clk) begin
        resp_t e;
        if (rvalid || req_seen) begin
            chk("rvalid_timing", rvalid, req_seen);
            if (rvalid) begin
                if (exp_q.size() == 0) chk("unexpected_rsp", 1, 0);
                else begin
                    e = exp_q.pop_front();
                    chk({e.nm, " rdata"}, rdata, e.rdata);
                    chk({e.nm, " err"}, err, e.err);
                end
            end
        end
    end

    // serial monitor: decodes 8N1 frames of bit_len cycles per bit and checks every cycle of the frame
    always begin
        logic [7:0] d;
        bit         bad;
        int         s;
        @(negedge clk);
        if (tx_on && tx === 1'b0) begin
            mon_busy = 1; s = cyc; bad = 0; d = 0;
            for (int i = 1; i < bit_len; i++) begin
                @(negedge clk);
                if (tx !== 1'b0) bad = 1;
            end
            for (int b = 0; b < 8; b++)
                for (int i = 0; i < bit_len; i++) begin
                    @(negedge clk);
                    if (i == 0) d[b] = tx;
                    else if (tx !== d[b]) bad = 1;
                end
            for (int i = 0; i < bit_len; i++) begin
                @(negedge clk);
                if (tx !== 1'b1) bad = 1;
            end
            starts.push_back(s);
            chk("frame_shape", bad, 0);
            if (tx_exp_q.size() == 0) chk("unexpected_frame", 1, 0);
            else chk("frame_byte", d, tx_exp_q.pop_front());
            mon_busy = 0;
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        int t, t1, n, lows;
        logic [7:0] d;
        repeat (3) @(negedge clk);
        chk("rst tx", tx, 1);
        chk("rst rvalid", rvalid, 0);
        chk("rst rdata", rdata, 0);
        chk("rst err", err, 0);
        chk("rst irq", irq, 0);
        rst_n = 1;
        @(negedge clk);
        issue(0, 2, 4'hF, 0, 32'd433, 0, "rd DIV reset", t);
        issue(0, 1, 4'hF, 0, 32'h2, 0, "rd STATUS reset", t);
        issue(0, 3, 4'hF, 0, 32'h0, 0, "rd CTRL reset", t);

        issue(1, 2, 4'h3, 32'h3, 0, 0, "wr DIV 3", t);
        issue(1, 3, 4'h1, 32'h1, 0, 0, "wr CTRL 1", t);
        bit_len = 4; tx_on = 1; starts.delete(); tx_exp_q.push_back(8'hA5);
        issue(1, 0, 4'h1, 32'hA5, 0, 0, "push A5", t);
        repeat (4) @(negedge clk);
        issue(0, 1, 4'hF, 0, 32'hA, 0, "STATUS busy", n);
        wait_drain(100, "drain A5");
        chk("A5 latency", starts.size() > 0 ? starts[0] : 0, t + 1);
        issue(0, 1, 4'hF, 0, 32'h2, 0, "STATUS idle", n);

        issue(1, 2, 4'h3, 32'h0, 0, 0, "wr DIV 0", t);
        bit_len = 1;
        issue(1, 3, 4'h1, 32'h0, 0, 0, "wr CTRL 0", t);
        for (int i = 0; i < 16; i++) begin
            d = 8'(i * 37 + 5);
            tx_exp_q.push_back(d);
            issue(1, 0, 4'h1, {24'h0, d}, 0, 0, "push fill", t);
        end
        issue(1, 0, 4'hE, 32'h77, 0, 0, "push be0 full", t);
        issue(1, 0, 4'h1, 32'h99, 0, 1, "push 17th", t);
        issue(0, 1, 4'hF, 0, 32'h5, 0, "STATUS full ovf", t);
        issue(0, 1, 4'hF, 0, 32'h1, 0, "STATUS ovf cleared", t);
        issue(1, 3, 4'h1, 32'h1, 0, 0, "wr CTRL txen", t);
        wait_drain(400, "drain fifo");
        issue(0, 1, 4'hF, 0, 32'h2, 0, "STATUS drained", t);

        issue(1, 3, 4'h1, 32'h3, 0, 0, "wr CTRL 3", t);
        starts.delete();
        tx_exp_q.push_back(8'h00);
        tx_exp_q.push_back(8'hFF);
        issue(1, 0, 4'h1, 32'h00, 0, 0, "push 00", t1);
        issue(1, 0, 4'h1, 32'hFF, 0, 0, "push FF", t);
        wait_drain(100, "drain pair");
        chk("pair start", starts.size() > 1 ? starts[0] : 0, t1 + 1);
        chk("pair gap", starts.size() > 1 ? starts[1] - starts[0] : 0, 10);
        n = 0;
        while (irq !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("irq rise cycle", cyc, t1 + 22);

        issue(1, 1, 4'hF, 32'hFF, 0, 1, "wr STATUS", t);
        issue(0, 1, 4'hF, 0, 32'h2, 0, "b2b STATUS", t);
        issue(0, 0, 4'hF, 0, 32'h0, 0, "b2b TXDATA", t);
        issue(0, 2, 4'hF, 0, 32'h0, 0, "b2b DIV", t);
        issue(0, 3, 4'hF, 0, 32'h3, 0, "b2b CTRL", t);
        issue(0, 1, 4'hF, 0, 32'h2, 0, "b2b STATUS2", t);
        chk("irq held", irq, 1);

        tx_on = 0;
        issue(1, 2, 4'h1, 32'hFFFF_FF03, 0, 0, "wr DIV lo byte", t);
        issue(1, 3, 4'h1, 32'h1, 0, 0, "wr CTRL txen only", t);
        issue(0, 2, 4'hF, 0, 32'h3, 0, "rd DIV be gated", t);
        issue(1, 0, 4'h1, 32'hA5, 0, 0, "push A5 again", t);
        issue(1, 0, 4'h1, 32'h3C, 0, 0, "push 3C", t);
        repeat (10) @(negedge clk);
        chk("tx mid data", tx, 0);
        #2 rst_n = 0;
        #1 chk("async reset tx", tx, 1);
        repeat (2) @(negedge clk);
        rst_n = 1;
        @(negedge clk);
        issue(0, 1, 4'hF, 0, 32'h2, 0, "STATUS after reset", t);
        issue(0, 3, 4'hF, 0, 32'h0, 0, "CTRL after reset", t);
        issue(0, 2, 4'hF, 0, 32'd433, 0, "DIV after reset", t);
        lows = 0;
        repeat (60) begin
            @(negedge clk);
            if (tx !== 1'b1) lows++;
        end
        chk("no residual frame", lows, 0);
        chk("responses consumed", exp_q.size(), 0);
        $display("%0d/%0d checks passed", pass, total);
        $finish;
    end
endmodule
